// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: shares the PCIe TX stream between the tunnelled-TLP
// FIFO (A) and the local requester FIFO (B), one whole TLP at a time.
module tlp_tx_arbiter #(
    parameter logic       PRIO_A    = 1'b0,
    parameter logic [9:0] MAX_WORDS = 10'd514
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [71:0] a_dout,
    input  logic        a_empty,
    output logic        a_rd_en,
    input  logic [71:0] b_dout,
    input  logic        b_empty,
    output logic        b_rd_en,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic [15:0] tlp_count_a,
    output logic [15:0] tlp_count_b,
    output logic [15:0] gap_drop_count,
    output logic        err_overlen,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t      state_q;
    logic        rr_last_q;
    logic [9:0]  wcnt_q;
    logic [9:0]  wcnt_d;
    logic [63:0] tdata_q;
    logic [7:0]  tkeep_q;
    logic        tlast_q;
    logic        tvalid_q;
    logic [15:0] cnt_a_q;
    logic [15:0] cnt_b_q;
    logic [15:0] gap_q;
    logic [15:0] gap_d;
    logic        err_q;

    logic        out_free;
    logic        rdy_a;
    logic        rdy_b;
    logic        grant_a;
    logic        grant_b;
    logic [71:0] sel_dout;
    logic        load;
    logic        drop_a;
    logic        drop_b;
    logic        overlen;
    logic        unused_sel;

    assign out_free = !tvalid_q | s_axis_tx_tready;
    assign rdy_a    = !a_empty & a_dout[64];
    assign rdy_b    = !b_empty & b_dout[64];

    // rr_last_q set means B went last, so A wins the next tie
    assign grant_a = rdy_a & (!rdy_b | PRIO_A | rr_last_q);
    assign grant_b = rdy_b & !grant_a;

    // FIFO pops: gap words drain freely, data words wait for the output slot
    always_comb begin
        a_rd_en = 1'b0;
        b_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                a_rd_en = !a_empty & !a_dout[64];
                b_rd_en = !b_empty & !b_dout[64];
            end
            GNT_A: a_rd_en = !a_empty & (a_dout[64] ? out_free : 1'b1);
            GNT_B: b_rd_en = !b_empty & (b_dout[64] ? out_free : 1'b1);
            default: ;
        endcase
    end

    assign sel_dout = (state_q == GNT_B) ? b_dout : a_dout;
    assign load = ((state_q == GNT_A) & a_rd_en & a_dout[64])
                | ((state_q == GNT_B) & b_rd_en & b_dout[64]);
    assign drop_a = a_rd_en & !a_dout[64];
    assign drop_b = b_rd_en & !b_dout[64];
    assign gap_d  = gap_q + {15'd0, drop_a} + {15'd0, drop_b};

    // Word count saturates so a runaway TLP cannot wrap it back under the limit
    assign wcnt_d  = (wcnt_q == MAX_WORDS) ? wcnt_q : wcnt_q + 10'd1;
    assign overlen = load & !sel_dout[65]
                   & (({1'b0, wcnt_q} + 11'd1) >= {1'b0, MAX_WORDS});

    assign unused_sel = ^{sel_dout[71:68], sel_dout[64]};

    // Grant FSM with per-source TLP counters, word count and length error
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            wcnt_q    <= 10'd0;
            cnt_a_q   <= 16'd0;
            cnt_b_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_a) begin
                        state_q <= GNT_A;
                    end else if (grant_b) begin
                        state_q <= GNT_B;
                    end
                end
                GNT_A, GNT_B: begin
                    if (load) begin
                        if (sel_dout[65]) begin
                            state_q   <= IDLE;
                            rr_last_q <= (state_q == GNT_B);
                            wcnt_q    <= 10'd0;
                            if (state_q == GNT_A) begin
                                cnt_a_q <= cnt_a_q + 16'd1;
                            end else begin
                                cnt_b_q <= cnt_b_q + 16'd1;
                            end
                        end else begin
                            wcnt_q <= wcnt_d;
                            if (overlen) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register: load on a data pop, otherwise retire on tready
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            tdata_q  <= 64'd0;
            tkeep_q  <= 8'd0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (load) begin
            tdata_q  <= sel_dout[63:0];
            tkeep_q  <= {{4{sel_dout[67]}}, {4{sel_dout[66]}}};
            tlast_q  <= sel_dout[65];
            tvalid_q <= 1'b1;
        end else if (s_axis_tx_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // Gap-word drop counter, both sources may drop in one cycle
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            gap_q <= 16'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign s_axis_tx_tvalid = tvalid_q;
    assign tlp_count_a      = cnt_a_q;
    assign tlp_count_b      = cnt_b_q;
    assign gap_drop_count   = gap_q;
    assign err_overlen      = err_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb_tlp_tx_arbiter: directed bench, FWFT FIFO models on both sources,
// dut0 round-robin with MAX_WORDS=4, dut1 with A priority.
module tb_tlp_tx_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tready = 1'b1;

    logic [71:0] a_dout0 = '0;
    logic        a_empty0 = 1'b1;
    logic        a_rd0;
    logic [71:0] b_dout0 = '0;
    logic        b_empty0 = 1'b1;
    logic        b_rd0;
    logic [63:0] tdata0;
    logic [7:0]  tkeep0;
    logic        tlast0;
    logic        tvalid0;
    logic [15:0] cnta0;
    logic [15:0] cntb0;
    logic [15:0] gap0;
    logic        err0;
    logic        busy0;

    logic [71:0] a_dout1 = '0;
    logic        a_empty1 = 1'b1;
    logic        a_rd1;
    logic [71:0] b_dout1 = '0;
    logic        b_empty1 = 1'b1;
    logic        b_rd1;
    logic [63:0] tdata1;
    logic [7:0]  tkeep1;
    logic        tlast1;
    logic        tvalid1;
    logic [15:0] cnta1;
    logic [15:0] cntb1;
    logic [15:0] gap1;
    logic        err1;
    logic        busy1;

    logic [71:0] qa0[$];
    logic [71:0] qb0[$];
    logic [71:0] qa1[$];
    logic [71:0] qb1[$];
    logic [72:0] out0[$];
    logic [72:0] out1[$];
    logic [72:0] ex[$];

    int checks = 0;
    int errors = 0;
    bit pa0, pb0, pa1, pb1;

    tlp_tx_arbiter #(.PRIO_A(1'b0), .MAX_WORDS(10'd4)) dut0 (
        .clk(clk), .sys_rst(sys_rst),
        .a_dout(a_dout0), .a_empty(a_empty0), .a_rd_en(a_rd0),
        .b_dout(b_dout0), .b_empty(b_empty0), .b_rd_en(b_rd0),
        .s_axis_tx_tdata(tdata0), .s_axis_tx_tkeep(tkeep0),
        .s_axis_tx_tlast(tlast0), .s_axis_tx_tvalid(tvalid0),
        .s_axis_tx_tready(tready),
        .tlp_count_a(cnta0), .tlp_count_b(cntb0),
        .gap_drop_count(gap0), .err_overlen(err0), .busy(busy0)
    );

    tlp_tx_arbiter #(.PRIO_A(1'b1)) dut1 (
        .clk(clk), .sys_rst(sys_rst),
        .a_dout(a_dout1), .a_empty(a_empty1), .a_rd_en(a_rd1),
        .b_dout(b_dout1), .b_empty(b_empty1), .b_rd_en(b_rd1),
        .s_axis_tx_tdata(tdata1), .s_axis_tx_tkeep(tkeep1),
        .s_axis_tx_tlast(tlast1), .s_axis_tx_tvalid(tvalid1),
        .s_axis_tx_tready(tready),
        .tlp_count_a(cnta1), .tlp_count_b(cntb1),
        .gap_drop_count(gap1), .err_overlen(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Output monitor plus FWFT FIFO models (pop sampled at the edge)
    always @(posedge clk) begin
        if (tvalid0 && tready) out0.push_back({tlast0, tkeep0, tdata0});
        if (tvalid1 && tready) out1.push_back({tlast1, tkeep1, tdata1});
        pa0 = a_rd0;
        pb0 = b_rd0;
        pa1 = a_rd1;
        pb1 = b_rd1;
        #1;
        if (pa0 && qa0.size() > 0) void'(qa0.pop_front());
        if (pb0 && qb0.size() > 0) void'(qb0.pop_front());
        if (pa1 && qa1.size() > 0) void'(qa1.pop_front());
        if (pb1 && qb1.size() > 0) void'(qb1.pop_front());
        a_dout0  = qa0.size() > 0 ? qa0[0] : '0;
        a_empty0 = qa0.size() == 0;
        b_dout0  = qb0.size() > 0 ? qb0[0] : '0;
        b_empty0 = qb0.size() == 0;
        a_dout1  = qa1.size() > 0 ? qa1[0] : '0;
        a_empty1 = qa1.size() == 0;
        b_dout1  = qb1.size() > 0 ? qb1[0] : '0;
        b_empty1 = qb1.size() == 0;
    end

    task automatic check(input string tag, input logic [72:0] got,
                         input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [3:0] f,
                                       input logic [63:0] d);
        return {4'b0000, f, d};
    endfunction

    // Expected forwarded word {tlast, tkeep, tdata} from flags {b67,b66,b65,b64}
    function automatic logic [72:0] ew(input logic [3:0] f,
                                       input logic [63:0] d);
        return {f[1], {4{f[3]}}, {4{f[2]}}, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tlp(input int d, input bit src_b,
                            input logic [63:0] base, input int n);
        logic [3:0] f;
        for (int i = 0; i < n; i++) begin
            f = (i == n - 1) ? 4'b1111 : 4'b1101;
            if (d == 0 && !src_b) qa0.push_back(mk(f, base + 64'(i)));
            if (d == 0 &&  src_b) qb0.push_back(mk(f, base + 64'(i)));
            if (d == 1 && !src_b) qa1.push_back(mk(f, base + 64'(i)));
            if (d == 1 &&  src_b) qb1.push_back(mk(f, base + 64'(i)));
        end
    endtask

    task automatic add_exp(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++)
            ex.push_back(ew((i == n - 1) ? 4'b1111 : 4'b1101,
                            base + 64'(i)));
    endtask

    task automatic cmp_out(input string tag, input int d);
        logic [72:0] got[$];
        got = (d == 1) ? out1 : out0;
        check({tag, "_len"}, 73'(got.size()), 73'(ex.size()));
        for (int i = 0; i < ex.size() && i < got.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got[i], ex[i]);
    endtask

    task automatic wait_tv(input string tag);
        int n = 0;
        while (!tvalid0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tvalid"}, 73'(tvalid0), 73'(1));
    endtask

    task automatic rst_all();
        @(negedge clk);
        sys_rst = 1'b1;
        tready  = 1'b1;
        qa0.delete();
        qb0.delete();
        qa1.delete();
        qb1.delete();
        tick(2);
        sys_rst = 1'b0;
        out0.delete();
        out1.delete();
        ex.delete();
    endtask

    initial begin : main
        logic [74:0] snap;
        bit bad;

        // reset state
        rst_all();
        check("reset_state",
              {tvalid0, busy0, err0, tlast0, cnta0, cntb0, gap0}, '0);

        // 1: single 3-word TLP on A with mixed byte enables
        qa0.push_back(mk(4'b1101, 64'h1111_0000_0000_0001));
        qa0.push_back(mk(4'b1101, 64'h1111_0000_0000_0002));
        qa0.push_back(mk(4'b0111, 64'h1111_0000_0000_0003));
        wait_tv("t1");
        check("t1_w1", {tlast0, tkeep0, tdata0},
              {1'b0, 8'hFF, 64'h1111_0000_0000_0001});
        check("t1_busy_mid", 73'(busy0), 73'(1));
        tick(1);
        check("t1_w2", {tvalid0, tlast0, tkeep0},
              {1'b1, 1'b0, 8'hFF});
        tick(1);
        check("t1_w3", {tvalid0, tlast0, tkeep0, tdata0},
              {1'b1, 1'b1, 8'h0F, 64'h1111_0000_0000_0003});
        check("t1_busy_end", 73'(busy0), 73'(0));
        check("t1_cnta", 73'(cnta0), 73'(1));
        tick(1);
        check("t1_tvalid_off", 73'(tvalid0), 73'(0));

        // 2 + 3: two 2-word TLPs per source, round-robin vs A priority
        rst_all();
        push_tlp(0, 1'b0, 64'hA100, 2);
        push_tlp(0, 1'b0, 64'hA200, 2);
        push_tlp(0, 1'b1, 64'hB100, 2);
        push_tlp(0, 1'b1, 64'hB200, 2);
        push_tlp(1, 1'b0, 64'hA100, 2);
        push_tlp(1, 1'b0, 64'hA200, 2);
        push_tlp(1, 1'b1, 64'hB100, 2);
        push_tlp(1, 1'b1, 64'hB200, 2);
        tick(30);
        add_exp(64'hA100, 2);
        add_exp(64'hB100, 2);
        add_exp(64'hA200, 2);
        add_exp(64'hB200, 2);
        cmp_out("t2_rr", 0);
        check("t2_counts", {cnta0, cntb0}, {16'd2, 16'd2});
        ex.delete();
        add_exp(64'hA100, 2);
        add_exp(64'hA200, 2);
        add_exp(64'hB100, 2);
        add_exp(64'hB200, 2);
        cmp_out("t3_prio", 1);
        check("t3_counts", {cnta1, cntb1}, {16'd2, 16'd2});

        // 4: four gap words ahead of a TLP
        rst_all();
        for (int i = 0; i < 4; i++)
            qa0.push_back(mk(4'b0000, 64'hDEAD));
        push_tlp(0, 1'b0, 64'h4EAD0, 2);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tvalid0 && gap0 < 16'd4) bad = 1'b1;
        end
        check("t4_no_tvalid_gap", 73'(bad), 73'(0));
        check("t4_gapcnt", 73'(gap0), 73'(4));
        add_exp(64'h4EAD0, 2);
        cmp_out("t4_out", 0);

        // 4b: gap words on A and B in the same cycle count twice
        rst_all();
        qa0.push_back(mk(4'b0000, 64'h0));
        qb0.push_back(mk(4'b0000, 64'h0));
        for (int i = 0; i < 10 && gap0 == 16'd0; i++) @(negedge clk);
        check("t4b_dual_drop", 73'(gap0), 73'(2));

        // 5: 5-clk backpressure in a 4-word TLP (exactly MAX_WORDS)
        rst_all();
        push_tlp(0, 1'b0, 64'h5500, 4);
        wait_tv("t5");
        tready = 1'b0;
        snap = {tvalid0, tlast0, tkeep0, tdata0};
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t5_stable%0d", i),
                  {tvalid0, tlast0, tkeep0, tdata0}, 73'(snap));
            check($sformatf("t5_rd%0d", i), 73'(a_rd0), 73'(0));
        end
        tready = 1'b1;
        tick(10);
        add_exp(64'h5500, 4);
        cmp_out("t5_out", 0);
        check("t5_no_err", 73'(err0), 73'(0));

        // 6: asynchronous reset mid-TLP, then a clean B TLP
        out0.delete();
        ex.delete();
        push_tlp(0, 1'b0, 64'h6600, 4);
        wait_tv("t6");
        tick(1);
        #2;
        sys_rst = 1'b1;
        qa0.delete();
        #1;
        check("t6_rst_data", 73'(tdata0), 73'(0));
        check("t6_rst_ctl", {tvalid0, tlast0, busy0, tkeep0}, '0);
        check("t6_rst_cnt", {cnta0, cntb0, gap0}, '0);
        tick(2);
        sys_rst = 1'b0;
        out0.delete();
        push_tlp(0, 1'b1, 64'hB600, 2);
        tick(15);
        add_exp(64'hB600, 2);
        cmp_out("t6_out", 0);
        check("t6_counts", {cnta0, cntb0}, {16'd0, 16'd1});

        // 7: 6-word TLP against MAX_WORDS=4
        rst_all();
        push_tlp(0, 1'b0, 64'h7700, 6);
        tick(20);
        check("t7_err", 73'(err0), 73'(1));
        add_exp(64'h7700, 6);
        cmp_out("t7_out", 0);
        push_tlp(0, 1'b0, 64'h7800, 2);
        tick(10);
        check("t7_err_sticky", 73'(err0), 73'(1));
        check("t7_cnta", 73'(cnta0), 73'(2));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
